// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit
// Hazard controller for the in-order pipeline, placed beside the ID stage. In-flight
// destinations are tracked in an internal scoreboard shift register. Multi-cycle ops
// hold ID for a programmable number of cycles after they issue.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   src1, src2      ID source registers; src2 only counts when Two_src is set
//   id_valid        ID holds a valid instruction
//   id_dest         ID destination register
//   id_wb_en        ID instruction writes the register file
//   id_mem_r_en     ID instruction is a load
//   id_mc_start     ID instruction is multi-cycle
//   id_mc_len       extra stall cycles for the multi-cycle op
//   flush           squash the ID instruction (taken branch)
//   Hazard          stall IF/ID this cycle (combinational)
//   mc_busy         multi-cycle counter nonzero
//   stall_count     saturating count of stall cycles
module hazard_ctrl_unit #(
  parameter int unsigned REG_W  = 4,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned FWD_EN = 0,
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  src1,
  input  logic [REG_W-1:0]  src2,
  input  logic              Two_src,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              id_mc_start,
  input  logic [CNT_W-1:0]  id_mc_len,
  input  logic              flush,
  output logic              Hazard,
  output logic              mc_busy,
  output logic [STAT_W-1:0] stall_count
);

  // Scoreboard: entry 0 is the instruction that left ID last cycle.
  logic [DEPTH-1:0] sb_v_q, sb_v_d;
  logic [DEPTH-1:0] sb_wb_q, sb_wb_d;
  logic [REG_W-1:0] sb_dest_q [DEPTH];
  logic [REG_W-1:0] sb_dest_d [DEPTH];
  // Only the youngest entry's load flag is ever consulted, so it is not shifted on.
  logic             sb_ld_q, sb_ld_d;

  logic [CNT_W-1:0]  mc_cnt_q, mc_cnt_d;
  logic [STAT_W-1:0] stall_count_q, stall_count_d;

  logic [DEPTH-1:0] src_match;
  logic             raw_all, raw_ld, raw, issue;

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      src_match[k] = sb_v_q[k] & sb_wb_q[k] &
                     ((src1 == sb_dest_q[k]) | (Two_src & (src2 == sb_dest_q[k])));
    end
    raw_all = |src_match;
    // With forwarding only a load one stage ahead cannot be bypassed in time.
    raw_ld  = src_match[0] & sb_ld_q;
    raw     = (FWD_EN != 0) ? raw_ld : raw_all;
    mc_busy = (mc_cnt_q != '0);
    Hazard  = id_valid & (raw | mc_busy);
    issue   = id_valid & ~Hazard & ~flush;
  end

  always_comb begin
    sb_v_d[0]    = issue;
    sb_wb_d[0]   = id_wb_en;
    sb_dest_d[0] = id_dest;
    sb_ld_d      = id_mem_r_en;
    for (int k = 1; k < DEPTH; k++) begin
      sb_v_d[k]    = sb_v_q[k-1];
      sb_wb_d[k]   = sb_wb_q[k-1];
      sb_dest_d[k] = sb_dest_q[k-1];
    end
  end

  always_comb begin
    mc_cnt_d = mc_cnt_q;
    if (issue && id_mc_start) begin
      mc_cnt_d = id_mc_len;
    end else if (mc_busy) begin
      // An issued multi-cycle op keeps counting through a flush.
      mc_cnt_d = mc_cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (id_valid && Hazard && !flush && !(&stall_count_q)) begin
      stall_count_d = stall_count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_v_q        <= '0;
      mc_cnt_q      <= '0;
      stall_count_q <= '0;
    end else begin
      sb_v_q        <= sb_v_d;
      mc_cnt_q      <= mc_cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Payload fields are qualified by sb_v_q and need no reset.
  always_ff @(posedge clk) begin
    sb_wb_q   <= sb_wb_d;
    sb_dest_q <= sb_dest_d;
    sb_ld_q   <= sb_ld_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src1, src2, id_dest, id_mc_len;
  logic       Two_src, id_valid, id_wb_en, id_mem_r_en, id_mc_start, flush;

  logic        haz0, busy0, haz1, busy1;
  logic [15:0] sc0;
  logic [3:0]  sc1;

  always #5 clk = ~clk;

  // dut0: no forwarding, DEPTH 2, wide counter. dut1: forwarding, DEPTH 3, 4-bit counter.
  hazard_ctrl_unit #(.REG_W(4), .DEPTH(2), .FWD_EN(0), .CNT_W(4), .STAT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .Two_src(Two_src),
    .id_valid(id_valid), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_mc_start(id_mc_start), .id_mc_len(id_mc_len),
    .flush(flush), .Hazard(haz0), .mc_busy(busy0), .stall_count(sc0)
  );

  hazard_ctrl_unit #(.REG_W(4), .DEPTH(3), .FWD_EN(1), .CNT_W(4), .STAT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .Two_src(Two_src),
    .id_valid(id_valid), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_mc_start(id_mc_start), .id_mc_len(id_mc_len),
    .flush(flush), .Hazard(haz1), .mc_busy(busy1), .stall_count(sc1)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference model: history of issue cycles rather than a shift register.
  int cyc = 0;
  bit chk_en = 1'b0;
  int last_wb   [2][16];  // cycle of latest issued writer of each register
  int prev_cyc  [2];      // cycle of latest issue of any instruction
  int prev_dest [2];
  bit prev_wb   [2];
  bit prev_ld   [2];
  int mc_until  [2];      // last cycle in which the multi-cycle op still holds ID
  int scount    [2];
  bit exp_haz   [2];

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 16; r++) last_wb[i][r] = -1000;
      prev_cyc[i] = -1000;
      prev_dest[i] = 0;
      prev_wb[i] = 1'b0;
      prev_ld[i] = 1'b0;
      mc_until[i] = -1000;
      scount[i] = 0;
      exp_haz[i] = 1'b0;
    end
  endtask

  // Compare process: evaluate the rules for the current ID inputs and check both DUTs.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int  depth;
        bit  raw, busy;
        int  act_h, act_b, act_s;
        depth = (i == 0) ? 2 : 3;
        raw = 1'b0;
        if (i == 0) begin
          if (cyc - last_wb[i][src1] <= depth) raw = 1'b1;
          if (Two_src && (cyc - last_wb[i][src2] <= depth)) raw = 1'b1;
        end else begin
          raw = (prev_cyc[i] == cyc - 1) && prev_wb[i] && prev_ld[i] &&
                ((int'(src1) == prev_dest[i]) || (Two_src && int'(src2) == prev_dest[i]));
        end
        busy = (cyc <= mc_until[i]);
        exp_haz[i] = id_valid && (raw || busy);
        act_h = (i == 0) ? int'(haz0) : int'(haz1);
        act_b = (i == 0) ? int'(busy0) : int'(busy1);
        act_s = (i == 0) ? int'(sc0) : int'(sc1);
        chk($sformatf("model_hazard[%0d]", i), act_h, int'(exp_haz[i]));
        chk($sformatf("model_mc_busy[%0d]", i), act_b, int'(busy));
        chk($sformatf("model_stall_count[%0d]", i), act_s, scount[i]);
      end
    end
  end

  // Model state update at the active edge.
  always @(posedge clk) begin
    if (rst) begin
      model_clear();
    end else if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        int smax;
        smax = (i == 0) ? 65535 : 15;
        if (id_valid && !exp_haz[i] && !flush) begin
          if (id_wb_en) last_wb[i][id_dest] = cyc;
          prev_cyc[i] = cyc;
          prev_dest[i] = int'(id_dest);
          prev_wb[i] = id_wb_en;
          prev_ld[i] = id_mem_r_en;
          if (id_mc_start) mc_until[i] = cyc + int'(id_mc_len);
        end
        if (id_valid && exp_haz[i] && !flush && scount[i] < smax) scount[i]++;
      end
    end
    if (rst) chk_en = 1'b1;
    cyc++;
  end

  task automatic set_in(input bit v, input int dest, input bit wb, input bit ld,
                        input int s1, input int s2, input bit two,
                        input bit mcs, input int mcl, input bit fl);
    id_valid = v; id_dest = 4'(dest); id_wb_en = wb; id_mem_r_en = ld;
    src1 = 4'(s1); src2 = 4'(s2); Two_src = two;
    id_mc_start = mcs; id_mc_len = 4'(mcl); flush = fl;
  endtask

  task automatic idle(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic at_neg(); @(negedge clk); endtask
  task automatic adv(); @(posedge clk); #1; endtask
  task automatic idle_n(input int n); idle(); for (int k = 0; k < n; k++) adv(); endtask

  initial begin
    model_clear();
    rst = 1'b1;
    idle();
    at_neg();
    chk("reset_hazard0", int'(haz0), 0);
    chk("reset_busy0", int'(busy0), 0);
    chk("reset_sc0", int'(sc0), 0);
    chk("reset_sc1", int'(sc1), 0);
    adv();
    rst = 1'b0;
    adv();

    // Back-to-back RAW: dut0 stalls 2, dut1 (forwarding, non-load) stalls 0.
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); at_neg(); chk("raw_a_nohaz", int'(haz0), 0); adv();
    set_in(1, 7, 1, 0, 3, 0, 0, 0, 0, 0);
    at_neg(); chk("raw_b_c1", int'(haz0), 1); chk("fwd_nonload", int'(haz1), 0); adv();
    at_neg(); chk("raw_b_c2", int'(haz0), 1); adv();
    at_neg(); chk("raw_b_issue", int'(haz0), 0); chk("raw_sc", int'(sc0), 2); adv();
    idle_n(3);

    // Two_src gating.
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); adv();
    set_in(1, 7, 0, 0, 1, 3, 0, 0, 0, 0); at_neg(); chk("two_src0", int'(haz0), 0); adv();
    idle_n(3);
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); adv();
    set_in(1, 7, 0, 0, 1, 3, 1, 0, 0, 0); at_neg(); chk("two_src1", int'(haz0), 1); adv();
    adv();
    at_neg(); chk("two_src1_issue", int'(haz0), 0); chk("two_src_sc", int'(sc0), 4); adv();
    idle_n(3);

    // Load-use: dut1 stalls exactly 1 cycle.
    set_in(1, 5, 1, 1, 0, 0, 0, 0, 0, 0); adv();
    set_in(1, 8, 0, 0, 5, 0, 0, 0, 0, 0);
    at_neg(); chk("ld_use_c1", int'(haz1), 1); chk("ld_use_raw0", int'(haz0), 1); adv();
    at_neg(); chk("ld_use_issue", int'(haz1), 0); adv();
    at_neg(); chk("ld_use_sc0", int'(sc0), 6); adv();
    idle_n(3);

    // Multi-cycle op of length 3, then length 0.
    set_in(1, 9, 0, 0, 0, 0, 0, 1, 3, 0); at_neg(); chk("mc_issue", int'(haz0), 0); adv();
    set_in(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    at_neg(); chk("mc_busy_c1", int'(busy0), 1); chk("mc_haz_c1", int'(haz0), 1); adv();
    at_neg(); chk("mc_haz_c2", int'(haz0), 1); adv();
    at_neg(); chk("mc_haz_c3", int'(haz1), 1); adv();
    at_neg(); chk("mc_done", int'(haz0), 0); chk("mc_busy_done", int'(busy0), 0);
    chk("mc_sc", int'(sc0), 9); adv();
    set_in(1, 9, 0, 0, 0, 0, 0, 1, 0, 0); adv();
    set_in(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    at_neg(); chk("mc0_nohaz", int'(haz0), 0); chk("mc0_nobusy", int'(busy0), 0); adv();
    idle_n(3);

    // Flush during a RAW stall.
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0); adv();
    set_in(1, 7, 0, 0, 3, 0, 0, 0, 0, 1);
    at_neg(); chk("flush_haz", int'(haz0), 1); chk("flush_sc_a", int'(sc0), 9); adv();
    set_in(1, 7, 0, 0, 3, 0, 0, 0, 0, 0);
    at_neg(); chk("flush_sc_b", int'(sc0), 9); chk("after_flush_haz", int'(haz0), 1); adv();
    at_neg(); chk("after_flush_issue", int'(haz0), 0); chk("after_flush_sc", int'(sc0), 10);
    adv();
    idle_n(3);

    // Reset in the middle of a 3-cycle multi-cycle stall.
    set_in(1, 9, 0, 0, 0, 0, 0, 1, 3, 0); adv();
    set_in(1, 2, 0, 0, 1, 0, 0, 0, 0, 0); at_neg(); chk("rst_mc_busy", int'(busy0), 1); adv();
    rst = 1'b1; adv(); rst = 1'b0;
    at_neg(); chk("rst_busy", int'(busy0), 0); chk("rst_haz", int'(haz0), 0);
    chk("rst_sc0", int'(sc0), 0); chk("rst_busy1", int'(busy1), 0); adv();
    idle_n(3);
    rst = 1'b1; adv(); rst = 1'b0; adv();

    // Saturation of the 4-bit counter over 20 stall cycles.
    set_in(1, 9, 0, 0, 0, 0, 0, 1, 15, 0); adv();
    set_in(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 15; k++) adv();
    at_neg(); chk("sat_sc1_15", int'(sc1), 15); chk("sat_sc0_15", int'(sc0), 15); adv();
    set_in(1, 9, 0, 0, 0, 0, 0, 1, 5, 0); adv();
    set_in(1, 2, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) adv();
    at_neg(); chk("sat_sc1_hold", int'(sc1), 15); chk("sat_sc0_20", int'(sc0), 20); adv();
    idle_n(3);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 4000; n++) begin
      set_in($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 9) == 0, $urandom_range(0, 5),
             $urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      adv();
    end
    rst = 1'b0;
    idle();
    adv();
    at_neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
